uart_word_tx: RTL
=================

# uart_word_tx

Serial transmitter for the SoC's host UART link. It accepts one 32-bit word per handshake and sends it on `tx` as four UART frames, least-significant byte first. Each frame is 1 start bit, 8 data bits LSB-first, 1 odd-parity bit and 1 stop bit. The frame format matches what the host sends into `rx`, so it carries write-back data and status words from `soc_top` to the host.

## Interface
- `CLKS_PER_BIT`, default 10: clock cycles per UART bit. The 100 ns clock gives a bit time of about 1 µs. Legal range is ≥ 2.
- `DATA_WIDTH`, default 32: word width. Fixed at 32, which is 4 bytes.

Ports:
- `clk`  in  1  system clock; all logic on the rising edge.
- `rst`  in  1  reset, synchronous, active-high.
- `in_data`  in  32  word to transmit; sampled on handshake.
- `in_valid`  in  1  producer has a word.
- `in_ready`  out  1  block can accept a word; high only in IDLE.
- `tx`  out  1  serial line; idles at 1; registered.
- `busy`  out  1  high from handshake until the last stop bit ends.
- `done`  out  1  one-cycle pulse when all 4 frames have been sent.

## Operation
- Word capture:
  - Handshake occurs when `in_valid && in_ready`.
  - `in_data` is latched into a 32-bit shift register.
  - The byte index is set to 0.
- States:
  - IDLE → START on handshake.
  - START (`tx`=0) → DATA after `CLKS_PER_BIT` cycles.
  - DATA (`tx`=current byte bit[n], n = 0..7) → PARITY after 8 bit-times.
  - PARITY (`tx` = ~^byte) → STOP after 1 bit-time.
  - STOP (`tx`=1) → START if the byte index < 3, with the index incremented; otherwise → IDLE.
- Odd parity: the count of ones across data plus parity is odd. Examples: 0x00 gives parity 1, 0xFF gives 1, 0x01 gives 0.
- Byte order: `in_data[7:0]` first, `in_data[31:24]` last.
- Counters:
  - Baud counter is $clog2(`CLKS_PER_BIT`) bits, counts 0..`CLKS_PER_BIT`-1, and wraps to 0 on each bit boundary.
  - Bit counter is 3 bits.
  - Byte index is 2 bits. It does not wrap: IDLE is entered instead.
- `in_data` and `in_valid` are ignored outside IDLE. A word presented while busy stays pending until `in_ready` rises.

## Timing
- Reset values, in effect the cycle after `rst` is sampled high:
  - State IDLE, `tx`=1, `busy`=0, `done`=0, `in_ready`=1.
  - All counters are 0 and the shift register is 0.
- Reset mid-frame:
  - The word is abandoned and `tx` returns to 1 the next cycle.
  - No `done` pulse is generated.
  - Reset has priority over a simultaneous handshake.
- Latency: on handshake at edge k, `tx` goes 0 and `busy` goes 1 from edge k+1.
- Each bit is held exactly `CLKS_PER_BIT` cycles. One frame is 11×`CLKS_PER_BIT` cycles; one word is 44×`CLKS_PER_BIT` cycles (440 at the default).
- Frames within a word are back-to-back: the next start bit follows the stop bit with no idle gap.
- End of word, on the cycle after the last stop bit-time expires:
  - State is IDLE, `done`=1 for exactly one cycle, `busy`=0 and `in_ready`=1.
- Back-to-back words: if `in_valid` is high in the `done` cycle, the handshake occurs there. The next start bit then begins one cycle later, so the inter-word stop time is `CLKS_PER_BIT`+1 cycles.
- `in_ready` is a function of state only; it never depends combinationally on `in_valid`.

## Test plan
- Instruction word: after reset, send 0x60011301 at `CLKS_PER_BIT`=10.
  - Decode `tx` by sampling at bit centres: bytes 0x01, 0x13, 0x01, 0x60 with parities 0, 0, 0, 1.
  - `done` pulses once, 441 cycles after the handshake.
- Parity corners:
  - 0x00000000 → all four parity bits are 1.
  - 0xFFFFFFFF → all four parity bits are 1.
  - 0x80000000 → parities 1, 1, 1, 0.
  - Every stop bit is 1 and every start bit is 0.
- Back-to-back: hold `in_valid` high with words 0xA5A5A5A5 then 0x0000003C.
  - The second handshake coincides with the first `done`.
  - Exactly `CLKS_PER_BIT`+1 cycles of `tx`=1 separate the two words.
  - `in_ready`=0 throughout both transmissions except the handshake cycle.
- Ignored input: pulse `in_valid` with 0xDEADBEEF during frame 2 of 0x12345678. The transmitted bytes stay 0x78, 0x56, 0x34, 0x12.
- Reset mid-frame: assert `rst` for one cycle during the DATA bits of byte 1.
  - `tx`=1, `busy`=0, `in_ready`=1 the next cycle, with no `done` pulse.
  - A following word 0x0000005A transmits correctly.
- Loopback: connect `tx` to the SoC UART receiver and send 0x80000000. The receiver reports 0x80000000 with no parity or framing error.

Source files
------------

// File: rtl/uart_word_tx.sv
// UART word transmitter: sends a 32-bit word as four 8O1 frames, least-significant byte first.
// One FSM drives the registered tx line and the busy/done status.
module uart_word_tx #(
   parameter int CLKS_PER_BIT = 10,
   parameter int DATA_WIDTH   = 32
) (
   input  logic                  clk,
   input  logic                  rst,
   input  logic [DATA_WIDTH-1:0] in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  tx,
   output logic                  busy,
   output logic                  done
);

   localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
   localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP
   } state_t;

   state_t                state_q;
   logic [BW-1:0]         baud_q;
   logic [2:0]            bit_q;
   logic [1:0]            byte_q;
   logic [DATA_WIDTH-1:0] shreg_q;
   logic                  tx_q;
   logic                  busy_q;
   logic                  done_q;

   logic                  bit_end;
   logic [7:0]            cur_byte;

   assign bit_end  = (baud_q == BAUD_LAST);
   assign cur_byte = shreg_q[7:0];

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= S_IDLE;
         baud_q  <= '0;
         bit_q   <= '0;
         byte_q  <= '0;
         shreg_q <= '0;
         tx_q    <= 1'b1;
         busy_q  <= 1'b0;
         done_q  <= 1'b0;
      end else begin
         done_q <= 1'b0;
         // The baud counter free-runs in every non-idle state and wraps on each bit boundary.
         if (state_q != S_IDLE) begin
            baud_q <= bit_end ? '0 : baud_q + 1'b1;
         end
         case (state_q)
            S_IDLE: begin
               if (in_valid) begin
                  shreg_q <= in_data;
                  byte_q  <= '0;
                  bit_q   <= '0;
                  baud_q  <= '0;
                  tx_q    <= 1'b0;
                  busy_q  <= 1'b1;
                  state_q <= S_START;
               end
            end
            S_START: begin
               if (bit_end) begin
                  bit_q   <= '0;
                  tx_q    <= cur_byte[0];
                  state_q <= S_DATA;
               end
            end
            S_DATA: begin
               if (bit_end) begin
                  if (bit_q == 3'd7) begin
                     tx_q    <= ~^cur_byte;
                     state_q <= S_PARITY;
                  end else begin
                     bit_q <= bit_q + 3'd1;
                     tx_q  <= cur_byte[bit_q + 3'd1];
                  end
               end
            end
            S_PARITY: begin
               if (bit_end) begin
                  bit_q   <= '0;
                  tx_q    <= 1'b1;
                  state_q <= S_STOP;
               end
            end
            S_STOP: begin
               if (bit_end) begin
                  // Next frame starts right after this stop bit; after the fourth, go idle.
                  if (byte_q != 2'd3) begin
                     byte_q  <= byte_q + 2'd1;
                     shreg_q <= shreg_q >> 8;
                     tx_q    <= 1'b0;
                     state_q <= S_START;
                  end else begin
                     busy_q  <= 1'b0;
                     done_q  <= 1'b1;
                     state_q <= S_IDLE;
                  end
               end
            end
            default: begin
               tx_q    <= 1'b1;
               busy_q  <= 1'b0;
               state_q <= S_IDLE;
            end
         endcase
      end
   end

   assign in_ready = (state_q == S_IDLE);
   assign tx       = tx_q;
   assign busy     = busy_q;
   assign done     = done_q;

endmodule
